wb_serial_master: RTL

- Wishbone classic initiator driven by a byte-stream command channel, typically a UART receive/transmit pair.
- Lets an external host issue single 32-bit reads and writes into the conbus address map as a second bus master. Intended uses are debug access and firmware loading.
- Parses command bytes, runs one Wishbone cycle and returns a response byte stream.

---
 rtl/wb_serial_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wb_serial_master.sv
// Byte-stream driven Wishbone classic initiator: parses write/read commands, runs one bus cycle, returns a response.
// Optional ack timeout is enabled by defining WB_SERIAL_MASTER_TIMEOUT_EN.
module wb_serial_master #(
    parameter logic [7:0] CMD_WRITE      = 8'h01,
    parameter logic [7:0] CMD_READ       = 8'h02,
    parameter logic [7:0] ACK_BYTE       = 8'hA5,
    parameter logic [7:0] ERR_BYTE       = 8'hEE,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic        cyc_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] resp_q;
    logic [1:0]  cnt_q;
    logic [1:0]  nleft_q;
    logic [31:0] adr_d;
    logic [31:0] dat_d;
    logic        tmo_hit;

    assign adr_d = {adr_q[23:0], rx_data};
    assign dat_d = {dat_q[23:0], rx_data};

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;

    // Held at zero outside BUS, so it starts from zero on every BUS entry.
    always_ff @(posedge clk) begin
        if (reset || state_q != BUS) tmo_q <= '0;
        else                         tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            resp_q     <= 32'h0;
            cnt_q      <= 2'd0;
            nleft_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        cnt_q <= 2'd0;
                        if (rx_data == CMD_WRITE) begin
                            we_q    <= 1'b1;
                            state_q <= ADDR;
                        end else if (rx_data == CMD_READ) begin
                            we_q    <= 1'b0;
                            state_q <= ADDR;
                        end else begin
                            tx_data_q  <= ERR_BYTE;
                            tx_valid_q <= 1'b1;
                            nleft_q    <= 2'd0;
                            state_q    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        adr_q <= adr_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (we_q) begin
                                state_q <= WDATA;
                            end else begin
                                cyc_q   <= 1'b1;
                                state_q <= BUS;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        dat_q <= dat_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cyc_q   <= 1'b1;
                            state_q <= BUS;
                        end
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (wb_ack_i) begin
                        cyc_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= RESP;
                        if (we_q) begin
                            tx_data_q <= ACK_BYTE;
                            nleft_q   <= 2'd0;
                        end else begin
                            tx_data_q <= wb_dat_i[31:24];
                            resp_q    <= {wb_dat_i[23:0], 8'h00};
                            nleft_q   <= 2'd3;
                        end
                    end else if (tmo_hit) begin
                        cyc_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ERR_BYTE;
                        nleft_q    <= 2'd0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (tx_valid_q && tx_ready) begin
                        if (nleft_q == 2'd0) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            tx_data_q <= resp_q[31:24];
                            resp_q    <= {resp_q[23:0], 8'h00};
                            nleft_q   <= nleft_q - 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = 4'hF;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != IDLE);

endmodule
